// File: rtl/fetch_ctrl_if.sv
// Signal bundle between the fetch controller and its neighbours: hazard unit,
// branch/jump resolution, instruction memory and the PC / IF-ID registers.
// The master side is the fetch controller itself.
interface fetch_ctrl_if;
  logic        start_i;
  logic [31:0] pc_i;
  logic        hazard_i;
  logic        branch_taken_i;
  logic [31:0] branch_target_i;
  logic        jump_i;
  logic [31:0] jump_target_i;
  logic        imem_ack_i;
  logic        imem_req_o;
  logic [31:0] next_pc_o;
  logic        pc_we_o;
  logic        if_id_we_o;
  logic        if_id_flush_o;
  logic        err_o;
  logic [31:0] stall_cnt_o;

  modport master (
    input  start_i, pc_i, hazard_i, branch_taken_i, branch_target_i,
           jump_i, jump_target_i, imem_ack_i,
    output imem_req_o, next_pc_o, pc_we_o, if_id_we_o, if_id_flush_o,
           err_o, stall_cnt_o
  );

  modport slave (
    output start_i, pc_i, hazard_i, branch_taken_i, branch_target_i,
           jump_i, jump_target_i, imem_ack_i,
    input  imem_req_o, next_pc_o, pc_we_o, if_id_we_o, if_id_flush_o,
           err_o, stall_cnt_o
  );
endinterface

// File: rtl/fetch_ctrl.sv
// Fetch controller: one-shot boot, then per-cycle selection of the next PC
// (sequential, branch or jump), load-use stalls, instruction-memory wait
// handling with a timeout that parks the block in a sticky error state.
// Redirects that arrive while memory has not acknowledged are parked in a
// single pending slot; the oldest one wins and is applied on the first ack.
module fetch_ctrl #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] PC_STEP  = 32'd4,
  parameter int unsigned MAX_WAIT = 16
) (
  input  logic          clk_i,
  input  logic          rst_i,
  fetch_ctrl_if.master  bus
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BOOT  = 2'd1,
    RUN   = 2'd2,
    ERROR = 2'd3
  } state_t;

  localparam logic [7:0] WAIT_LIMIT = 8'(MAX_WAIT);

  state_t      state;
  logic        pend_valid;
  logic [31:0] pend_target;
  logic [7:0]  wait_cnt;
  logic [31:0] stall_cnt;
  logic        err;

  logic        new_valid;
  logic [31:0] new_target;
  logic        redir_valid;
  logic [31:0] redir_target;
  logic        timeout;

  logic        imem_req;
  logic [31:0] next_pc;
  logic        pc_we;
  logic        if_id_we;
  logic        if_id_flush;

  // Pick this cycle's redirect (branch is older than jump) and let an already
  // pending target take precedence over anything younger.
  always_comb begin
    new_valid    = bus.branch_taken_i | bus.jump_i;
    new_target   = bus.branch_taken_i ? bus.branch_target_i : bus.jump_target_i;
    redir_valid  = pend_valid | new_valid;
    redir_target = pend_valid ? pend_target : new_target;
    timeout      = (wait_cnt + 8'd1) == WAIT_LIMIT;
  end

  // Decode the PC / IF-ID controls from state, inputs and the pending slot.
  always_comb begin
    imem_req    = 1'b0;
    next_pc     = bus.pc_i;
    pc_we       = 1'b0;
    if_id_we    = 1'b0;
    if_id_flush = 1'b0;
    if (!rst_i) begin
      next_pc = RESET_PC;
    end else begin
      case (state)
        BOOT: begin
          next_pc     = RESET_PC;
          pc_we       = 1'b1;
          if_id_flush = 1'b1;
        end
        RUN: begin
          imem_req = 1'b1;
          if (!bus.imem_ack_i) begin
            if_id_flush = 1'b1;
          end else if (redir_valid) begin
            next_pc     = redir_target;
            pc_we       = 1'b1;
            if_id_flush = 1'b1;
          end else if (!bus.hazard_i) begin
            next_pc  = bus.pc_i + PC_STEP;
            pc_we    = 1'b1;
            if_id_we = 1'b1;
          end
        end
        ERROR: begin
          if_id_flush = 1'b1;
        end
        default: begin
        end
      endcase
    end
  end

  // State, pending redirect, wait/stall counters and the sticky error flag.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state       <= IDLE;
      pend_valid  <= 1'b0;
      pend_target <= '0;
      wait_cnt    <= '0;
      stall_cnt   <= '0;
      err         <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.start_i) state <= BOOT;
        end
        BOOT: begin
          state <= RUN;
        end
        RUN: begin
          if (!pc_we && (stall_cnt != 32'hFFFF_FFFF)) stall_cnt <= stall_cnt + 32'd1;
          if (!bus.imem_ack_i) begin
            if (!pend_valid && new_valid) begin
              pend_valid  <= 1'b1;
              pend_target <= new_target;
            end
            wait_cnt <= wait_cnt + 8'd1;
            if (timeout) begin
              state <= ERROR;
              err   <= 1'b1;
            end
          end else begin
            pend_valid <= 1'b0;
            wait_cnt   <= '0;
          end
        end
        ERROR: begin
          err <= 1'b1;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  assign bus.imem_req_o    = imem_req;
  assign bus.next_pc_o     = next_pc;
  assign bus.pc_we_o       = pc_we;
  assign bus.if_id_we_o    = if_id_we;
  assign bus.if_id_flush_o = if_id_flush;
  assign bus.err_o         = err;
  assign bus.stall_cnt_o   = stall_cnt;

endmodule

// File: tb/tb_fetch_ctrl.sv
// Bench for fetch_ctrl: a directed vector table for boot, load-use, branch vs
// jump and redirect-during-miss, hand sequences for wrap, timeout and async
// reset, and randomized traffic compared against a behavioural model.
module tb_fetch_ctrl;
  localparam logic [31:0] RESET_PC = 32'h0000_0000;
  localparam logic [31:0] PC_STEP  = 32'd4;
  localparam int          MAX_WAIT = 16;
  localparam bit H = 1'b1;
  localparam bit L = 1'b0;

  typedef struct packed {
    logic        start;
    logic        hazard;
    logic        branch;
    logic [31:0] branch_target;
    logic        jump;
    logic [31:0] jump_target;
    logic        ack;
  } in_t;

  typedef struct packed {
    logic        req;
    logic        pc_we;
    logic        if_id_we;
    logic        flush;
    logic [31:0] next_pc;
    logic        err;
    logic [31:0] stall_cnt;
  } out_t;

  typedef struct packed {
    in_t  stim;
    out_t want;
  } vec_t;

  logic clk_i;
  logic rst_i;
  fetch_ctrl_if bus();

  fetch_ctrl #(
    .RESET_PC(RESET_PC),
    .PC_STEP (PC_STEP),
    .MAX_WAIT(MAX_WAIT)
  ) dut (
    .clk_i(clk_i),
    .rst_i(rst_i),
    .bus  (bus)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  // Behavioural model: boot progress flags, every redirect seen since the last
  // acked fetch (oldest applies), run length of un-acked cycles, stall count.
  logic        m_started;
  logic        m_boot_done;
  logic        m_failed;
  logic [31:0] m_redirects[$];
  int          m_miss_run;
  logic [31:0] m_stall;
  logic [31:0] pc_reg;
  out_t        expected;
  int          vec_count;
  int          miss_count;
  vec_t        vecs[17];

  function automatic in_t mkIn(bit st, bit hz, bit br, logic [31:0] bt, bit jp, logic [31:0] jt, bit ack);
    in_t s;
    s.start = st; s.hazard = hz; s.branch = br; s.branch_target = bt;
    s.jump = jp; s.jump_target = jt; s.ack = ack;
    return s;
  endfunction

  function automatic out_t mkOut(bit rq, bit we, bit ifwe, bit fl, logic [31:0] nxt, bit er, logic [31:0] stl);
    out_t o;
    o.req = rq; o.pc_we = we; o.if_id_we = ifwe; o.flush = fl;
    o.next_pc = nxt; o.err = er; o.stall_cnt = stl;
    return o;
  endfunction

  function automatic void modelReset();
    m_started   = 1'b0;
    m_boot_done = 1'b0;
    m_failed    = 1'b0;
    m_redirects.delete();
    m_miss_run  = 0;
    m_stall     = '0;
  endfunction

  function automatic out_t modelExpect();
    out_t        o;
    logic        have;
    logic [31:0] tgt;
    o = '0;
    o.next_pc   = bus.pc_i;
    o.err       = m_failed;
    o.stall_cnt = m_stall;
    have = 1'b0;
    tgt  = '0;
    if (!rst_i) begin
      o.next_pc   = RESET_PC;
      o.err       = 1'b0;
      o.stall_cnt = '0;
    end else if (m_failed) begin
      o.flush = 1'b1;
    end else if (m_started && !m_boot_done) begin
      o.next_pc = RESET_PC;
      o.pc_we   = 1'b1;
      o.flush   = 1'b1;
    end else if (m_boot_done) begin
      o.req = 1'b1;
      if (m_redirects.size() > 0) begin
        have = 1'b1; tgt = m_redirects[0];
      end else if (bus.branch_taken_i) begin
        have = 1'b1; tgt = bus.branch_target_i;
      end else if (bus.jump_i) begin
        have = 1'b1; tgt = bus.jump_target_i;
      end
      if (!bus.imem_ack_i) begin
        o.flush = 1'b1;
      end else if (have) begin
        o.next_pc = tgt;
        o.pc_we   = 1'b1;
        o.flush   = 1'b1;
      end else if (!bus.hazard_i) begin
        o.next_pc  = bus.pc_i + PC_STEP;
        o.pc_we    = 1'b1;
        o.if_id_we = 1'b1;
      end
    end
    return o;
  endfunction

  function automatic void modelStep();
    if (m_failed) begin
    end else if (!m_started) begin
      m_started = bus.start_i;
    end else if (!m_boot_done) begin
      m_boot_done = 1'b1;
    end else begin
      if (!expected.pc_we && m_stall != 32'hFFFF_FFFF) m_stall = m_stall + 32'd1;
      if (bus.imem_ack_i) begin
        m_redirects.delete();
        m_miss_run = 0;
      end else begin
        if (bus.branch_taken_i) m_redirects.push_back(bus.branch_target_i);
        else if (bus.jump_i) m_redirects.push_back(bus.jump_target_i);
        m_miss_run++;
        if (m_miss_run >= MAX_WAIT) m_failed = 1'b1;
      end
    end
  endfunction

  task automatic setInputs(input in_t s);
    bus.start_i         = s.start;
    bus.hazard_i        = s.hazard;
    bus.branch_taken_i  = s.branch;
    bus.branch_target_i = s.branch_target;
    bus.jump_i          = s.jump;
    bus.jump_target_i   = s.jump_target;
    bus.imem_ack_i      = s.ack;
    bus.pc_i            = pc_reg;
  endtask

  task automatic applyStimulus(input in_t s);
    @(negedge clk_i);
    setInputs(s);
    #1;
    expected = modelExpect();
  endtask

  task automatic clockEdge();
    @(posedge clk_i);
    if (rst_i) begin
      if (expected.pc_we) pc_reg = expected.next_pc;
      modelStep();
    end
  endtask

  task automatic checkOutput(input string name, input out_t want);
    out_t got;
    got.req       = bus.imem_req_o;
    got.pc_we     = bus.pc_we_o;
    got.if_id_we  = bus.if_id_we_o;
    got.flush     = bus.if_id_flush_o;
    got.next_pc   = bus.next_pc_o;
    got.err       = bus.err_o;
    got.stall_cnt = bus.stall_cnt_o;
    vec_count++;
    if (got !== want) begin
      miss_count++;
      $display("[TB] FAIL %s: got req=%b we=%b ifwe=%b flush=%b next=%h err=%b stall=%0d, required req=%b we=%b ifwe=%b flush=%b next=%h err=%b stall=%0d",
               name, got.req, got.pc_we, got.if_id_we, got.flush, got.next_pc, got.err, got.stall_cnt,
               want.req, want.pc_we, want.if_id_we, want.flush, want.next_pc, want.err, want.stall_cnt);
    end
  endtask

  task automatic resetDut();
    @(negedge clk_i);
    setInputs(mkIn(L, L, L, 32'h0, L, 32'h0, L));
    rst_i = 1'b0;
    modelReset();
    #1;
    checkOutput("in_reset", mkOut(L, L, L, L, RESET_PC, L, 32'd0));
    @(negedge clk_i);
    rst_i = 1'b1;
  endtask

  task automatic randomCycle(input string name);
    in_t         s;
    logic [31:0] r1;
    logic [31:0] r2;
    r1 = $urandom;
    r2 = $urandom;
    s = mkIn($urandom_range(0, 19) == 0, $urandom_range(0, 5) == 0,
             $urandom_range(0, 7) == 0, {r1[31:2], 2'b00},
             $urandom_range(0, 7) == 0, {r2[31:2], 2'b00},
             $urandom_range(0, 9) != 0);
    applyStimulus(s);
    checkOutput(name, expected);
    clockEdge();
  endtask

  initial begin
    vec_count  = 0;
    miss_count = 0;
    pc_reg     = 32'h0000_1230;
    rst_i      = 1'b0;
    modelReset();
    setInputs(mkIn(L, L, L, 32'h0, L, 32'h0, L));
    expected = '0;

    vecs[0]  = '{mkIn(L,L,L,32'h0,  L,32'h0,  H), mkOut(L,L,L,L,32'h1230,L,32'd0)};
    vecs[1]  = '{mkIn(H,L,L,32'h0,  L,32'h0,  H), mkOut(L,L,L,L,32'h1230,L,32'd0)};
    vecs[2]  = '{mkIn(L,L,L,32'h0,  L,32'h0,  H), mkOut(L,H,L,H,32'h0,   L,32'd0)};
    vecs[3]  = '{mkIn(L,L,L,32'h0,  L,32'h0,  H), mkOut(H,H,H,L,32'h4,   L,32'd0)};
    vecs[4]  = '{mkIn(L,L,L,32'h0,  L,32'h0,  H), mkOut(H,H,H,L,32'h8,   L,32'd0)};
    vecs[5]  = '{mkIn(H,L,L,32'h0,  L,32'h0,  H), mkOut(H,H,H,L,32'hC,   L,32'd0)};
    vecs[6]  = '{mkIn(L,L,L,32'h0,  L,32'h0,  H), mkOut(H,H,H,L,32'h10,  L,32'd0)};
    vecs[7]  = '{mkIn(L,H,L,32'h0,  L,32'h0,  H), mkOut(H,L,L,L,32'h10,  L,32'd0)};
    vecs[8]  = '{mkIn(L,H,L,32'h0,  L,32'h0,  H), mkOut(H,L,L,L,32'h10,  L,32'd1)};
    vecs[9]  = '{mkIn(L,L,L,32'h0,  L,32'h0,  H), mkOut(H,H,H,L,32'h14,  L,32'd2)};
    vecs[10] = '{mkIn(L,L,H,32'h100,H,32'h200,H), mkOut(H,H,L,H,32'h100, L,32'd2)};
    vecs[11] = '{mkIn(L,L,L,32'h0,  L,32'h0,  H), mkOut(H,H,H,L,32'h104, L,32'd2)};
    vecs[12] = '{mkIn(L,L,L,32'h0,  L,32'h0,  L), mkOut(H,L,L,H,32'h104, L,32'd2)};
    vecs[13] = '{mkIn(L,L,L,32'h0,  H,32'h40, L), mkOut(H,L,L,H,32'h104, L,32'd3)};
    vecs[14] = '{mkIn(L,L,H,32'h80, L,32'h0,  L), mkOut(H,L,L,H,32'h104, L,32'd4)};
    vecs[15] = '{mkIn(L,L,L,32'h0,  L,32'h0,  H), mkOut(H,H,L,H,32'h40,  L,32'd5)};
    vecs[16] = '{mkIn(L,L,L,32'h0,  L,32'h0,  H), mkOut(H,H,H,L,32'h44,  L,32'd5)};

    resetDut();

    for (int i = 0; i < 17; i++) begin
      applyStimulus(vecs[i].stim);
      checkOutput($sformatf("vec%0d", i), vecs[i].want);
      clockEdge();
    end

    // Sequential fetch from the top of the address space wraps to zero.
    pc_reg = 32'hFFFF_FFFC;
    applyStimulus(mkIn(L, L, L, 32'h0, L, 32'h0, H));
    checkOutput("pc_wrap", mkOut(H, H, H, L, 32'h0, L, 32'd5));
    clockEdge();

    // Hold ack low until the fetch times out.
    for (int i = 0; i < MAX_WAIT; i++) begin
      applyStimulus(mkIn(L, L, L, 32'h0, L, 32'h0, L));
      checkOutput($sformatf("miss%0d", i), expected);
      clockEdge();
    end
    applyStimulus(mkIn(H, L, L, 32'h0, L, 32'h0, H));
    checkOutput("error_entered", mkOut(L, L, L, H, 32'h0, H, 32'd21));
    clockEdge();
    for (int i = 0; i < 4; i++) randomCycle($sformatf("error_hold%0d", i));

    // Randomized traffic with occasional resets.
    resetDut();
    for (int i = 0; i < 600; i++) begin
      if (i % 150 == 149) resetDut();
      randomCycle($sformatf("rand%0d", i));
    end

    // Asynchronous reset in the middle of a miss with a redirect pending.
    resetDut();
    applyStimulus(mkIn(H, L, L, 32'h0, L, 32'h0, H));
    checkOutput("ar_idle_start", expected);
    clockEdge();
    for (int i = 0; i < 4; i++) begin
      applyStimulus(mkIn(L, L, L, 32'h0, L, 32'h0, H));
      checkOutput($sformatf("ar_run%0d", i), expected);
      clockEdge();
    end
    applyStimulus(mkIn(L, L, L, 32'h0, H, 32'h300, L));
    checkOutput("ar_miss_jump", expected);
    clockEdge();
    applyStimulus(mkIn(L, L, L, 32'h0, L, 32'h0, L));
    checkOutput("ar_miss_pending", expected);
    #1;
    rst_i = 1'b0;
    modelReset();
    #1;
    checkOutput("ar_async_reset", mkOut(L, L, L, L, RESET_PC, L, 32'd0));
    @(posedge clk_i);
    @(negedge clk_i);
    rst_i = 1'b1;
    for (int i = 0; i < 3; i++) begin
      applyStimulus(mkIn(L, L, H, 32'h500, L, 32'h0, H));
      checkOutput($sformatf("ar_idle%0d", i), mkOut(L, L, L, L, pc_reg, L, 32'd0));
      clockEdge();
    end
    applyStimulus(mkIn(H, L, L, 32'h0, L, 32'h0, H));
    checkOutput("ar_restart", expected);
    clockEdge();
    applyStimulus(mkIn(L, L, L, 32'h0, L, 32'h0, H));
    checkOutput("ar_boot", mkOut(L, H, L, H, RESET_PC, L, 32'd0));
    clockEdge();
    applyStimulus(mkIn(L, L, L, 32'h0, L, 32'h0, H));
    checkOutput("ar_no_stale_redirect", mkOut(H, H, H, L, RESET_PC + PC_STEP, L, 32'd0));
    clockEdge();

    $display("== %0d vectors applied, %0d miscompares ==", vec_count, miss_count);
    $finish;
  end
endmodule
